execute_cycle: RTL
==================

# execute_cycle

Execute stage of the five-stage RISC-V pipeline. Consumes the ID/EX register outputs produced by the decode stage, resolves operand forwarding, performs the ALU operation, and resolves branch/jump redirection. Drives the combinational redirect (PCSrcE, PCTargetE) back to fetch and registers the EX/MEM pipeline register feeding the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, jumpE  in  1 each  control signals from ID/EX.
- ALUControlE  in  3  ALU operation select.
- RD1_E, RD2_E  in  32  register-file read data from ID/EX.
- Imm_Ext_E  in  32  sign-extended immediate.
- RD_E  in  5  destination register.
- PCE, PCPlus4E  in  32  instruction PC and PC+4.
- ForwardA_E, ForwardB_E  in  2  forwarding selects from the hazard unit.
- ResultW  in  32  writeback result (forward source).
- ALU_ResultM_in  in  32  current EX/MEM ALU result (forward source).
- PCSrcE  out  1  combinational redirect request to fetch.
- PCTargetE  out  32  combinational branch/jump target.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls.
- RD_M  out  5  registered destination register.
- PCPlus4M  out  32  registered PC+4.
- WriteDataM  out  32  registered store data (forwarded operand B).
- ALU_ResultM  out  32  registered ALU result.

## Operation
- Forwarding: SrcA = RD1_E when ForwardA_E = 00, ResultW when 01, ALU_ResultM_in when 10. Code 11 is reserved and behaves as 00. The same rules apply to ForwardB_E selecting the forwarded B value from RD2_E.
- SrcB = Imm_Ext_E when ALUSrcE = 1, otherwise the forwarded B value.
- ALU operations, all arithmetic modulo 2^32:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 101 SLT: result is 32'h1 when $signed(A) < $signed(B), else 0.
  - Codes 100, 110, 111 produce 0.
- ZeroE = (ALU result == 0). It is internal and not registered.
- PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^32.
- PCSrcE = (ZeroE & BranchE) | jumpE.
- WriteDataM captures the forwarded B value, never the immediate.

## Timing
- ALU result, ZeroE, PCSrcE and PCTargetE are combinational within the cycle.
- EX/MEM register has 1-cycle latency: values present in EX at edge n appear on the *M outputs after edge n.
- Reset asserted (rst = 0): all registered outputs go to 0 immediately, without waiting for a clock edge. This covers RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM and ALU_ResultM.
- PCSrcE and PCTargetE are not reset. They follow their inputs, which are themselves 0 while decode is held in reset.
- Reset deasserted mid-operation: the first capture happens on the next rising edge. There is no partial state.
- The register updates every cycle. There is no stall or flush port; bubbles arrive as zeroed controls from ID/EX.
- Simultaneous ForwardA_E = ForwardB_E = 10 is legal. Both operands take ALU_ResultM_in.

## Structure
- A shared package holds:
  - ALU opcode constants: ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101.
  - Forward-select constants: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, alu, is natural. It takes A, B and ALUControl and returns Result and Zero, and is instantiated once.
- The forward muxes, target adder and EX/MEM register stay in execute_cycle.

## Test plan
- Reset: hold rst = 0 with nonzero inputs, including a clock edge. All *M outputs read 0. Release rst; the next edge captures the inputs.
- ADD with immediate: RD1_E = 5, Imm_Ext_E = 7, ALUSrcE = 1, ALUControlE = 000. After one edge, ALU_ResultM = 12 and WriteDataM = RD2_E.
- Forwarding: RD1_E = 1, ALU_ResultM_in = 100, ResultW = 50, ForwardA_E = 10, ForwardB_E = 01, SUB. ALU_ResultM = 50 and WriteDataM = 50. With ForwardA_E = 11, ALU_ResultM = −49 (32'hFFFFFFCF).
- SLT signed: A = 32'hFFFFFFFF, B = 1, ALUControlE = 101. Result is 1. Swapping the operands gives 0.
- BEQ taken: SUB with A = B = 9, BranchE = 1, PCE = 32'h100, Imm_Ext_E = 32'hFFFFFFF0. PCSrcE = 1 and PCTargetE = 32'hF0 in the same cycle. Setting A = 8 gives PCSrcE = 0.
- JAL: jumpE = 1, BranchE = 0, nonzero ALU result. PCSrcE = 1. After one edge, PCPlus4M = PCPlus4E and RD_M = RD_E.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forward selects
// and the layout of the EX/MEM pipeline register.
package execute_cycle_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] write_data;
        logic [31:0] alu_result;
    } ex_mem_t;

    // Code 11 is reserved and falls back to the register-file value.
    function automatic logic [31:0] forward_pick(input logic [1:0]  sel,
                                                 input logic [31:0] rf_value,
                                                 input logic [31:0] wb_value,
                                                 input logic [31:0] mem_value);
        logic [31:0] picked;
        picked = rf_value;
        case (sel)
            FWD_WB:  picked = wb_value;
            FWD_MEM: picked = mem_value;
            default: picked = rf_value;
        endcase
        return picked;
    endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage: add, sub, and, or, signed
// set-less-than; unused opcodes yield zero.
module execute_cycle_alu
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            less_signed;

    assign sum         = a + b;
    assign diff        = a - b;
    assign less_signed = ($signed(a) < $signed(b));

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, less_signed};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect and the
// EX/MEM pipeline register feeding the memory stage.
module execute_cycle
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            jumpE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALU_ResultM_in,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;

    assign src_a = forward_pick(ForwardA_E, RD1_E, ResultW, ALU_ResultM_in);
    assign fwd_b = forward_pick(ForwardB_E, RD2_E, ResultW, ALU_ResultM_in);
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    execute_cycle_alu #(.XLEN(XLEN)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (ALUControlE),
        .result      (alu_result),
        .zero        (zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (zero & BranchE) | jumpE;

    // Store data is always the forwarded B operand, even for immediate ops.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.rd         = RD_E;
        ex_mem_d.pc_plus4   = PCPlus4E;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.alu_result = alu_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign RegWriteM   = ex_mem_q.reg_write;
    assign MemWriteM   = ex_mem_q.mem_write;
    assign ResultSrcM  = ex_mem_q.result_src;
    assign RD_M        = ex_mem_q.rd;
    assign PCPlus4M    = ex_mem_q.pc_plus4;
    assign WriteDataM  = ex_mem_q.write_data;
    assign ALU_ResultM = ex_mem_q.alu_result;

endmodule
